// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester and the software/bench side:
// FSM state encoding, timer register map and a counter-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } apb_state_e;

    localparam logic [2:0] TCNT = 3'd1;
    localparam logic [2:0] TDR  = 3'd2;
    localparam logic [2:0] TCR  = 3'd3;
    localparam logic [2:0] TSR  = 3'd4;

    // At least one bit so a disabled timeout (limit 0) still yields a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command/response and APB bus bundle for apb_master_ctrl.
// The master modport is the requester's view, the slave modport is the environment's view.
interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter; expired_o flags the cycle whose pready=0 edge
// would be the limit-th wait. A limit of 0 never expires.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: clear has priority, increment saturates at all-ones
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (limit_i != {CNT_W{1'b0}}) &&
                       (count_q >= (limit_i - CNT_W'(1'b1)));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 requester: one valid/ready command becomes one APB transfer, the
// result is reported as a single-cycle response; hung slaves are timed out.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    apb_master_ctrl_if.master    bus
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    apb_state_e            state_q;
    logic                  cmd_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    logic accept_s;
    logic wait_s;
    logic expired_s;

    assign accept_s = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
    assign wait_s   = (state_q == ST_ACCESS) && !bus.pready;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .pclk     (pclk),
        .preset_n (preset_n),
        .enable_i (wait_s),
        .clear_i  (accept_s),
        .limit_i  (CNT_W'(TIMEOUT_CYCLES)),
        .expired_o(expired_s)
    );

    // transfer sequencer; every bus and response output is a register here
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {ADDR_WIDTH{1'b0}};
            pwdata_q      <= {DATA_WIDTH{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q     <= ST_SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= bus.cmd_write;
                        paddr_q     <= bus.cmd_addr;
                        pwdata_q    <= bus.cmd_wdata;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    // pready wins over an expiring timeout on the same edge
                    if (bus.pready) begin
                        state_q       <= ST_RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? {DATA_WIDTH{1'b0}} : bus.prdata;
                        rsp_err_q     <= bus.pslverr;
                        rsp_timeout_q <= 1'b0;
                    end else if (expired_s) begin
                        state_q       <= ST_RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: each accepted command is expanded into the
// cycle-by-cycle picture it must produce, and a negedge process compares and drives.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic pclk     = 1'b0;
    logic preset_n = 1'b0;

    apb_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    apb_master_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        int         waits;
        bit         err;
    } cmd_t;

    typedef struct {
        bit         psel;
        bit         pen;
        bit         ready;
        bit         rvalid;
        bit         rerr;
        bit         rto;
        logic [7:0] rdata;
        bit         drv_pready;
        logic [7:0] drv_prdata;
        bit         drv_pslverr;
        bit         wr;
        logic [2:0] addr;
        logic [7:0] wdata;
    } exp_t;

    cmd_t       cmd_q[$];
    exp_t       exp_q[$];
    logic [7:0] mem [8];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc_cyc = 0;
    int dut_rsp_cyc = 0;
    bit fresh = 1'b1;
    logic [7:0] hold_rdata = 8'h00;
    bit hold_err = 1'b0;
    bit hold_to  = 1'b0;
    exp_t e_cur;
    cmd_t c_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t blank(input bit rdy);
        exp_t e;
        e.psel = 1'b0; e.pen = 1'b0; e.ready = rdy; e.rvalid = 1'b0;
        e.rerr = 1'b0; e.rto = 1'b0; e.rdata = 8'h00;
        e.drv_pready = 1'b0; e.drv_prdata = 8'hEE; e.drv_pslverr = 1'b0;
        e.wr = 1'b0; e.addr = 3'd0; e.wdata = 8'h00;
        return e;
    endfunction

    // Expand one accepted command: SETUP, n ACCESS cycles, RESP.
    task automatic push_seq(input cmd_t c);
        exp_t       e;
        logic [7:0] rd;
        bit         tmo;
        int         n;
        rd  = mem[c.addr];
        tmo = (TO != 0) && (c.waits >= TO);
        n   = tmo ? TO : c.waits + 1;
        e = blank(1'b0);
        e.psel = 1'b1; e.wr = c.wr; e.addr = c.addr; e.wdata = c.wdata;
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            e.pen         = 1'b1;
            e.drv_pready  = !tmo && (k == n - 1);
            e.drv_prdata  = e.drv_pready ? rd : 8'hEE;
            e.drv_pslverr = e.drv_pready ? c.err : 1'b1;
            exp_q.push_back(e);
        end
        e = blank(1'b0);
        e.rvalid = 1'b1;
        e.rerr   = tmo | c.err;
        e.rto    = tmo;
        e.rdata  = (tmo || c.wr) ? 8'h00 : rd;
        exp_q.push_back(e);
        if (c.wr && !tmo && !c.err) mem[c.addr] = c.wdata;
    endtask

    // per-cycle compare against the model, then drive inputs for the next edge
    always @(negedge pclk) begin
        cyc++;
        if (!preset_n) begin
            chk("rst_psel",      32'(bus.psel),        32'd0);
            chk("rst_penable",   32'(bus.penable),     32'd0);
            chk("rst_cmd_ready", 32'(bus.cmd_ready),   32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
            chk("rst_rsp_err",   32'(bus.rsp_err),     32'd0);
            chk("rst_rsp_to",    32'(bus.rsp_timeout), 32'd0);
            chk("rst_rsp_rdata", 32'(bus.rsp_rdata),   32'd0);
            chk("rst_pwrite",    32'(bus.pwrite),      32'd0);
            chk("rst_paddr",     32'(bus.paddr),       32'd0);
            chk("rst_pwdata",    32'(bus.pwdata),      32'd0);
            exp_q.delete();
            hold_rdata = 8'h00; hold_err = 1'b0; hold_to = 1'b0;
            fresh = 1'b1;
            bus.cmd_valid = 1'b0;
            bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 8'h00;
        end else begin
            if (exp_q.size() > 0) e_cur = exp_q.pop_front();
            else e_cur = blank(!fresh);
            fresh = 1'b0;
            if (e_cur.rvalid) begin
                hold_rdata = e_cur.rdata; hold_err = e_cur.rerr; hold_to = e_cur.rto;
            end
            if (bus.rsp_valid === 1'b1) dut_rsp_cyc = cyc;
            chk("psel",        32'(bus.psel),        32'(e_cur.psel));
            chk("penable",     32'(bus.penable),     32'(e_cur.pen));
            chk("cmd_ready",   32'(bus.cmd_ready),   32'(e_cur.ready));
            chk("rsp_valid",   32'(bus.rsp_valid),   32'(e_cur.rvalid));
            chk("rsp_rdata",   32'(bus.rsp_rdata),   32'(hold_rdata));
            chk("rsp_err",     32'(bus.rsp_err),     32'(hold_err));
            chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(hold_to));
            if (e_cur.psel) begin
                chk("paddr",  32'(bus.paddr),  32'(e_cur.addr));
                chk("pwrite", 32'(bus.pwrite), 32'(e_cur.wr));
                chk("pwdata", 32'(bus.pwdata), 32'(e_cur.wdata));
            end
            bus.pready  = e_cur.drv_pready;
            bus.prdata  = e_cur.drv_prdata;
            bus.pslverr = e_cur.drv_pslverr;
            if (cmd_q.size() > 0) begin
                c_cur = cmd_q[0];
                bus.cmd_valid = 1'b1;
                bus.cmd_write = c_cur.wr;
                bus.cmd_addr  = c_cur.addr;
                bus.cmd_wdata = c_cur.wdata;
                if (e_cur.ready) begin
                    void'(cmd_q.pop_front());
                    push_seq(c_cur);
                    prev_acc_cyc = acc_cyc;
                    acc_cyc = cyc;
                end
            end else begin
                bus.cmd_valid = 1'b0;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 3'd5;
                bus.cmd_wdata = 8'hA5;
            end
        end
    end

    task automatic issue(input bit wr, input logic [2:0] addr, input logic [7:0] wdata,
                         input int waits, input bit err);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.waits = waits; c.err = err;
        cmd_q.push_back(c);
    endtask

    task automatic run_until_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge pclk);
            #1;
            if (cmd_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
        end
        chk("drain_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_wdata = 8'h00;
        bus.pready = 1'b0; bus.prdata = 8'h00; bus.pslverr = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[1] = 8'h5A; mem[4] = 8'h77; mem[7] = 8'h3C;

        repeat (3) @(posedge pclk);
        #2 preset_n = 1'b1;
        #1 chk("ready_low_after_release", 32'(bus.cmd_ready), 32'd0);
        @(posedge pclk); #1;
        chk("ready_rises_first_edge", 32'(bus.cmd_ready), 32'd1);

        issue(1'b1, TCR, 8'hB0, 0, 1'b0);
        run_until_idle(50);
        chk("wr_latency", 32'(dut_rsp_cyc - acc_cyc), 32'd3);
        chk("wr_err",     32'(bus.rsp_err),           32'd0);

        issue(1'b0, TCNT, 8'h00, 2, 1'b0);
        run_until_idle(50);
        chk("rd_wait_latency", 32'(dut_rsp_cyc - acc_cyc), 32'd5);
        chk("rd_wait_data",    32'(bus.rsp_rdata),         32'h5A);

        issue(1'b0, 3'd7, 8'h00, 0, 1'b1);
        run_until_idle(50);
        chk("slverr_err", 32'(bus.rsp_err),     32'd1);
        chk("slverr_to",  32'(bus.rsp_timeout), 32'd0);

        issue(1'b0, TSR, 8'h00, 16, 1'b0);
        run_until_idle(80);
        chk("to_latency", 32'(dut_rsp_cyc - acc_cyc), 32'd18);
        chk("to_flag",    32'(bus.rsp_timeout),       32'd1);
        chk("to_rdata",   32'(bus.rsp_rdata),         32'h00);

        issue(1'b0, TSR, 8'h00, 15, 1'b0);
        run_until_idle(80);
        chk("edge_latency", 32'(dut_rsp_cyc - acc_cyc), 32'd18);
        chk("edge_no_to",   32'(bus.rsp_timeout),       32'd0);
        chk("edge_rdata",   32'(bus.rsp_rdata),         32'h77);

        issue(1'b1, TDR, 8'h10, 0, 1'b0);
        issue(1'b0, TDR, 8'hFF, 0, 1'b0);
        run_until_idle(80);
        chk("b2b_spacing", 32'(acc_cyc - prev_acc_cyc), 32'd4);
        chk("b2b_rdata",   32'(bus.rsp_rdata),          32'h10);

        issue(1'b0, 3'd5, 8'h00, 10, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge pclk); #1;
            if (bus.psel && bus.penable) break;
        end
        chk("reached_access", 32'(bus.penable), 32'd1);
        repeat (2) @(posedge pclk);
        #2 preset_n = 1'b0;
        #1;
        chk("async_psel",      32'(bus.psel),      32'd0);
        chk("async_penable",   32'(bus.penable),   32'd0);
        chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge pclk);
        #2 preset_n = 1'b1;
        @(posedge pclk); #1;
        chk("ready_after_midreset", 32'(bus.cmd_ready), 32'd1);

        issue(1'b1, 3'd6, 8'h42, 1, 1'b0);
        issue(1'b0, 3'd6, 8'h00, 0, 1'b0);
        run_until_idle(80);
        chk("post_reset_rdata", 32'(bus.rsp_rdata), 32'h42);

        repeat (2) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
